spi_link_host: RTL
==================

SPI_LINK_HOST -- requirements
Module: spi_link_host

Interface
REQ-001 Parameter GAP_CYCLES, default 8: idle clocks between consecutive bytes of one transaction.
REQ-002 Parameter RX_TIMEOUT, default 1024: max clocks waiting for rx_valid after a byte is accepted.
REQ-003 Ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-004 Ports: req_valid  in  1  request offered; req_ready  out  1  request accepted when both high.
REQ-005 Ports: req_op  in  2  operation; req_addr  in  7  register address; req_wdata  in  8  write data.
REQ-006 Ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  8  read data; rsp_err  out  1  timeout flag.
REQ-007 Ports: tx_byte  out  8  byte to SPI master; tx_valid  out  1  byte offered; tx_ready  in  1  byte taken.
REQ-008 Ports: rx_byte  in  8  byte shifted in; rx_valid  in  1  one-cycle strobe per completed byte.
REQ-009 Ports: cs_n  out  1  active-low frame select, low for the whole transaction.

Function
REQ-010 Block SHALL be the initiator of the spi_link_sm byte protocol; one transaction in flight at a time.
REQ-011 REG_WR (op 0) byte sequence SHALL be 0x89, {1,addr}, wdata, 0x00.
REQ-012 REG_RD (op 1) byte sequence SHALL be 0x89, {0,addr}, 0x00, 0x00; rsp_rdata = rx_byte of byte 3.
REQ-013 FIFO_RD (op 2) byte sequence SHALL be 0x8A, 0x00, 0x00; rsp_rdata = rx_byte of byte 2.
REQ-014 FIFO_WR (op 3) byte sequence SHALL be 0x8B, wdata.
REQ-015 FSM states: IDLE, SETUP, SEND, WAIT_RX, GAP, DONE.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready latch op/addr/wdata, drive cs_n low -> SETUP.
REQ-017 SETUP: one cycle, load byte 0 -> SEND.
REQ-018 SEND: tx_valid=1, tx_byte stable until tx_ready sampled high -> WAIT_RX.
REQ-019 WAIT_RX: on rx_valid capture rx_byte if it is the data byte; last byte -> DONE, else -> GAP.
REQ-020 GAP: count GAP_CYCLES clocks, load next byte -> SEND; GAP_CYCLES=0 SHALL go directly to SEND.
REQ-021 DONE: rsp_valid=1 for exactly one cycle, cs_n high same cycle -> IDLE; write ops return rsp_rdata=0.
REQ-022 Latency from accept to tx_valid of byte 0 SHALL be 2 clocks.
REQ-023 req_ready SHALL be 0 in every state except IDLE; requests in other states are not consumed.
REQ-024 rx_valid outside WAIT_RX SHALL be ignored with no state change.
REQ-025 rx_valid and tx_ready high in the same SEND cycle: rx_valid ignored, tx_ready honoured.
REQ-026 WAIT_RX lasting RX_TIMEOUT clocks SHALL abort: DONE with rsp_err=1, rsp_rdata=0, remaining bytes skipped.
REQ-027 Byte index and gap/timeout counters SHALL be sized by $clog2 of their maxima; no wrap within a transaction.

Reset
REQ-028 rst asserted SHALL immediately force IDLE, cs_n=1, tx_valid=0, rsp_valid=0, rsp_err=0, tx_byte=0, rsp_rdata=0, counters 0.
REQ-029 rst mid-transaction SHALL abandon it with no rsp_valid; first post-reset request starts a clean frame.
REQ-030 req_ready SHALL be 0 while rst is high and 1 from the first clock after release.

Structure
REQ-031 Shared package spi_link_pkg SHALL hold the op enum (REG_WR, REG_RD, FIFO_RD, FIFO_WR) and constants CMD_REG=0x89, CMD_FIFO_RD=0x8A, CMD_FIFO_WR=0x8B; spi_link_sm SHALL import the same package.
REQ-032 No sub-module; FSM, byte mux and counters are in one module.

Verification
REQ-033 REG_WR addr 0x24 data 0x00, tx_ready tied 1, rx echo -> bytes 89,A4,00,00; 8-clock gaps; one rsp_valid, rsp_err=0.
REQ-034 REG_RD addr 0x05, responder returns 00,00,00,5A -> bytes 89,05,00,00; rsp_rdata=0x5A.
REQ-035 512 FIFO_WR alternating 0xFE/0xBA back-to-back -> 1024 bytes in order, 512 rsp_valid pulses, cs_n high between frames.
REQ-036 FIFO_RD with rx_valid withheld -> rsp_valid after RX_TIMEOUT clocks, rsp_err=1, cs_n high.
REQ-037 rst pulsed during byte 2 of REG_WR -> cs_n=1 and tx_valid=0 immediately, no rsp_valid; next request completes normally.
REQ-038 tx_ready held low 20 clocks in SEND -> tx_byte/tx_valid stable throughout, stray rx_valid ignored.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Shared definitions for the spi_link byte protocol, used by both the host
// (initiator) and the spi_link_sm responder.
package spi_link_pkg;

    typedef enum logic [1:0] {
        REG_WR  = 2'd0,
        REG_RD  = 2'd1,
        FIFO_RD = 2'd2,
        FIFO_WR = 2'd3
    } op_e;

    localparam logic [7:0] CMD_REG     = 8'h89;
    localparam logic [7:0] CMD_FIFO_RD = 8'h8A;
    localparam logic [7:0] CMD_FIFO_WR = 8'h8B;

    // Longest frame is four bytes, so a 2-bit index covers every operation.
    localparam int MAX_BYTES = 4;
    localparam int IDX_W     = $clog2(MAX_BYTES);

    function automatic logic [IDX_W-1:0] last_index(input op_e op);
        case (op)
            REG_WR, REG_RD: last_index = 2'd3;
            FIFO_RD:        last_index = 2'd2;
            default:        last_index = 2'd1;
        endcase
    endfunction

    function automatic logic is_data_byte(input op_e op, input logic [IDX_W-1:0] idx);
        is_data_byte = ((op == REG_RD) && (idx == 2'd3)) ||
                       ((op == FIFO_RD) && (idx == 2'd2));
    endfunction

    function automatic logic [7:0] frame_byte(input op_e op,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [6:0] addr,
                                              input logic [7:0] wdata);
        frame_byte = 8'h00;
        case (op)
            REG_WR: begin
                case (idx)
                    2'd0:    frame_byte = CMD_REG;
                    2'd1:    frame_byte = {1'b1, addr};
                    2'd2:    frame_byte = wdata;
                    default: frame_byte = 8'h00;
                endcase
            end
            REG_RD: begin
                case (idx)
                    2'd0:    frame_byte = CMD_REG;
                    2'd1:    frame_byte = {1'b0, addr};
                    default: frame_byte = 8'h00;
                endcase
            end
            FIFO_RD: frame_byte = (idx == 2'd0) ? CMD_FIFO_RD : 8'h00;
            default: frame_byte = (idx == 2'd0) ? CMD_FIFO_WR : wdata;
        endcase
    endfunction

endpackage

// File: rtl/spi_link_host.sv
// Initiator side of the spi_link byte protocol: turns one register/FIFO
// request into a framed byte sequence for an SPI master and returns a response.
module spi_link_host
    import spi_link_pkg::*;
#(
    parameter int GAP_CYCLES = 8,
    parameter int RX_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       cs_n
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TO_W  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SEND    = 3'd2,
        WAIT_RX = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e           state, state_next;
    op_e              op_q;
    logic [6:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] load_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       tx_byte_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic             accept;
    logic             is_last;
    logic             timeout;
    logic             load_byte;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign is_last   = (idx == last_index(op_q));
    assign timeout   = (state == WAIT_RX) && !rx_valid && (to_cnt == TO_W'(RX_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        load_idx   = idx;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = SEND;
            SEND:    if (tx_ready) state_next = WAIT_RX;
            WAIT_RX: begin
                // With no gap the next byte is loaded straight from WAIT_RX,
                // before idx has advanced.
                load_idx = idx + 2'd1;
                if (rx_valid) begin
                    if (is_last)              state_next = DONE;
                    else if (GAP_CYCLES == 0) state_next = SEND;
                    else                      state_next = GAP;
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = SEND;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load_byte = (state_next == SEND) && (state != SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= REG_WR;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            tx_byte_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_e'(req_op);
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        idx     <= '0;
                        gap_cnt <= '0;
                        to_cnt  <= '0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                WAIT_RX: begin
                    if (rx_valid) begin
                        to_cnt  <= '0;
                        gap_cnt <= '0;
                        if (is_data_byte(op_q, idx)) rdata_q <= rx_byte;
                        if (!is_last) idx <= idx + 2'd1;
                    end else if (timeout) begin
                        to_cnt  <= '0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    if (state_next == SEND) gap_cnt <= '0;
                    else                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                DONE: tx_byte_q <= '0;
                default: ;
            endcase
            if (load_byte) tx_byte_q <= frame_byte(op_q, load_idx, addr_q, wdata_q);
        end
    end

    assign tx_valid  = (state == SEND);
    assign rsp_valid = (state == DONE);
    assign cs_n      = !((state == SETUP) || (state == SEND) ||
                         (state == WAIT_RX) || (state == GAP));
    assign tx_byte   = tx_byte_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
